// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard inputs and stall/forward outputs for hazard_scoreboard.
// The master side is the controller/pipeline and the slave side is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 3,
    parameter int TW     = 2
);
    logic [NSRC*ADDR_W-1:0] d_src_addr;
    logic [NSRC-1:0]        d_src_used;
    logic [NSRC*TW-1:0]     d_src_tuse;
    logic                   d_wen;
    logic [ADDR_W-1:0]      d_dst;
    logic [TW-1:0]          d_tnew;
    logic                   d_md_use;
    logic                   d_md_start;
    logic                   d_md_div;
    logic                   stall;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_clr;
    logic [NSRC*2-1:0]      fwd_d;
    logic [NSRC*2-1:0]      fwd_e;
    logic                   md_busy;

    modport master (
        output d_src_addr, d_src_used, d_src_tuse, d_wen, d_dst, d_tnew,
               d_md_use, d_md_start, d_md_div,
        input  stall, pc_en, ifid_en, idex_clr, fwd_d, fwd_e, md_busy
    );

    modport slave (
        input  d_src_addr, d_src_used, d_src_tuse, d_wen, d_dst, d_tnew,
               d_md_use, d_md_start, d_md_div,
        output stall, pc_en, ifid_en, idex_clr, fwd_d, fwd_e, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew scoreboard hazard unit with E/M/W writer tracking and a HI/LO busy counter.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / md_stall_cycles counters.
module hazard_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int NSRC    = 3,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        stall_cycles,
    output logic [31:0]        md_stall_cycles,
`endif
    hazard_scoreboard_if.slave hz
);
    logic                   r_e_vld, r_m_vld, r_w_vld;
    logic [ADDR_W-1:0]      r_e_dst, r_m_dst, r_w_dst;
    logic [TW-1:0]          r_e_tnew, r_m_tnew, r_w_tnew;
    logic [NSRC*ADDR_W-1:0] r_es_addr;
    logic [NSRC-1:0]        r_es_used;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_data_stall, w_md_busy, w_md_stall, w_stall;
    logic [NSRC*2-1:0]      w_fwd_d, w_fwd_e;
    logic [ADDR_W-1:0]      w_a;
    logic [TW-1:0]          w_tuse, w_t;
    logic                   w_hit;
    logic [1:0]             w_sel;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_vld   <= 1'b0;
            r_m_vld   <= 1'b0;
            r_w_vld   <= 1'b0;
            r_e_dst   <= '0;
            r_m_dst   <= '0;
            r_w_dst   <= '0;
            r_e_tnew  <= '0;
            r_m_tnew  <= '0;
            r_w_tnew  <= '0;
            r_es_addr <= '0;
            r_es_used <= '0;
            r_cnt     <= '0;
        end else begin
            // A stalled D instruction becomes a bubble in E: no writer, no consumer.
            if (w_stall) begin
                r_e_vld   <= 1'b0;
                r_es_used <= '0;
            end else begin
                r_e_vld   <= hz.d_wen && (hz.d_dst != '0);
                r_es_used <= hz.d_src_used;
            end
            r_e_dst   <= hz.d_dst;
            r_e_tnew  <= hz.d_tnew;
            r_es_addr <= hz.d_src_addr;
            r_m_vld   <= r_e_vld;
            r_m_dst   <= r_e_dst;
            r_m_tnew  <= dec_sat(r_e_tnew);
            r_w_vld   <= r_m_vld;
            r_w_dst   <= r_m_dst;
            r_w_tnew  <= dec_sat(r_m_tnew);
            if (hz.d_md_start && !w_stall) begin
                r_cnt <= hz.d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_data_stall = 1'b0;
        w_fwd_d      = '0;
        w_fwd_e      = '0;
        w_a          = '0;
        w_tuse       = '0;
        w_t          = '0;
        w_hit        = 1'b0;
        w_sel        = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            // D side: youngest matching writer among E, M, W.
            w_a    = hz.d_src_addr[i*ADDR_W +: ADDR_W];
            w_tuse = hz.d_src_tuse[i*TW +: TW];
            w_hit  = 1'b1;
            if (r_e_vld && r_e_dst == w_a) begin
                w_t = r_e_tnew; w_sel = 2'b01;
            end else if (r_m_vld && r_m_dst == w_a) begin
                w_t = r_m_tnew; w_sel = 2'b10;
            end else if (r_w_vld && r_w_dst == w_a) begin
                w_t = r_w_tnew; w_sel = 2'b11;
            end else begin
                w_t = '0; w_sel = 2'b00; w_hit = 1'b0;
            end
            if (hz.d_src_used[i] && w_a != '0 && w_hit) begin
                if (w_t > w_tuse) w_data_stall = 1'b1;
                if (w_t == '0) w_fwd_d[i*2 +: 2] = w_sel;
            end
            // E side: only M and W can still supply the instruction now in E.
            w_a   = r_es_addr[i*ADDR_W +: ADDR_W];
            w_hit = 1'b1;
            if (r_m_vld && r_m_dst == w_a) begin
                w_t = r_m_tnew; w_sel = 2'b01;
            end else if (r_w_vld && r_w_dst == w_a) begin
                w_t = r_w_tnew; w_sel = 2'b10;
            end else begin
                w_t = '0; w_sel = 2'b00; w_hit = 1'b0;
            end
            if (r_es_used[i] && w_a != '0 && w_hit && w_t == '0) begin
                w_fwd_e[i*2 +: 2] = w_sel;
            end
        end
    end

    always_comb begin
        w_md_busy  = (r_cnt != '0);
        w_md_stall = hz.d_md_use && w_md_busy;
        w_stall    = w_data_stall || w_md_stall;
    end

    assign hz.stall    = !reset && w_stall;
    assign hz.pc_en    = reset || !w_stall;
    assign hz.ifid_en  = reset || !w_stall;
    assign hz.idex_clr = !reset && w_stall;
    assign hz.fwd_d    = reset ? '0 : w_fwd_d;
    assign hz.fwd_e    = reset ? '0 : w_fwd_e;
    assign hz.md_busy  = !reset && w_md_busy;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles    <= '0;
            md_stall_cycles <= '0;
        end else begin
            if (w_stall)    stall_cycles    <= stall_cycles + 32'd1;
            if (w_md_stall) md_stall_cycles <= md_stall_cycles + 32'd1;
        end
    end
`endif
endmodule
